// File: rtl/drv_switch_array_if.sv
// Switch-array bundle: raw pads in, debounced levels and gesture events out.
interface drv_switch_array_if #(
  parameter int unsigned p_channels = 4
);
  logic [p_channels-1:0] i_drv_sw;
  logic [p_channels-1:0] o_press;
  logic [p_channels-1:0] o_click;
  logic [p_channels-1:0] o_release;
  logic [p_channels-1:0] o_edge;
  logic [p_channels-1:0] o_toggle;
  logic [p_channels-1:0] o_long;
  logic [p_channels-1:0] o_hold;
  logic [p_channels-1:0] o_double;

  modport slave (
    input  i_drv_sw,
    output o_press, o_click, o_release, o_edge, o_toggle, o_long, o_hold, o_double
  );

  modport master (
    output i_drv_sw,
    input  o_press, o_click, o_release, o_edge, o_toggle, o_long, o_hold, o_double
  );
endinterface

// File: rtl/drv_switch_array.sv
// Multi-channel switch driver: sync, debounce, edge/toggle outputs and
// per-channel long-press / double-click gesture FSM.
module drv_switch_array #(
  parameter int unsigned            p_channels    = 4,
  parameter int unsigned            p_scale       = 5,
  parameter logic [p_channels-1:0]  p_pullup_mask = '1,
  parameter int unsigned            p_long        = 50_000_000,
  parameter int unsigned            p_dbl         = 15_000_000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  drv_switch_array_if.slave    sw_if
);

  localparam int unsigned DBW  = p_scale;
  localparam int unsigned MAXC = (p_long > p_dbl) ? p_long : p_dbl;
  localparam int unsigned CW   = $clog2(MAXC);
  localparam logic [CW-1:0] LONG_LAST = CW'(p_long - 1);
  localparam logic [CW-1:0] DBL_LAST  = CW'(p_dbl - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESS  = 3'd1,
    S_LONG   = 3'd2,
    S_WAIT   = 3'd3,
    S_DPRESS = 3'd4
  } state_e;

  for (genvar n = 0; n < p_channels; n++) begin : g_ch
    logic           raw_active;
    logic [1:0]     sync_q;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           level_q, level_d;
    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
    logic           rise_c, fall_c, long_c, dbl_c;
    logic           press_q, click_q, release_q, edge_q;
    logic           toggle_q, long_q, hold_q, double_q;

    assign raw_active = sw_if.i_drv_sw[n] ^ p_pullup_mask[n];

    // Synchroniser and debounce registers; level_q is the debounced level one cycle ahead of o_press.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        sync_q   <= 2'b00;
        db_cnt_q <= '0;
        level_q  <= 1'b0;
      end else begin
        sync_q   <= {sync_q[0], raw_active};
        db_cnt_q <= db_cnt_d;
        level_q  <= level_d;
      end
    end

    always_comb begin
      db_cnt_d = '0;
      level_d  = level_q;
      if (sync_q[1] != level_q) begin
        if (db_cnt_q == '1) level_d = sync_q[1];
        else                db_cnt_d = db_cnt_q + DBW'(1);
      end
    end

    assign rise_c  = level_q & ~press_q;
    assign fall_c  = ~level_q & press_q;
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

    // Gesture FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Next state; a click landing on the window's last edge starts a fresh press
    always_comb begin
      state_d = state_q;
      unique case (state_q)
        S_IDLE:   if (rise_c) state_d = S_PRESS;
        S_PRESS: begin
          if (fall_c)                     state_d = S_WAIT;
          else if (cnt_inc == LONG_LAST)  state_d = S_LONG;
        end
        S_LONG:   if (fall_c) state_d = S_IDLE;
        S_WAIT: begin
          if (cnt_inc == DBL_LAST)        state_d = rise_c ? S_PRESS : S_IDLE;
          else if (rise_c)                state_d = S_DPRESS;
        end
        S_DPRESS: begin
          if (fall_c)                     state_d = S_IDLE;
          else if (cnt_inc == LONG_LAST)  state_d = S_LONG;
        end
        default:                          state_d = S_IDLE;
      endcase
      cnt_d = (state_d != state_q) ? '0 : cnt_inc;
    end

    // FSM event decode, registered below alongside the edge pulses
    always_comb begin
      long_c = 1'b0;
      dbl_c  = 1'b0;
      if ((state_q == S_PRESS || state_q == S_DPRESS) && !fall_c && cnt_inc == LONG_LAST)
        long_c = 1'b1;
      if (state_q == S_WAIT && rise_c && cnt_inc != DBL_LAST)
        dbl_c = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        press_q   <= 1'b0;
        click_q   <= 1'b0;
        release_q <= 1'b0;
        edge_q    <= 1'b0;
        toggle_q  <= 1'b0;
        long_q    <= 1'b0;
        hold_q    <= 1'b0;
        double_q  <= 1'b0;
      end else begin
        press_q   <= level_q;
        click_q   <= rise_c;
        release_q <= fall_c;
        edge_q    <= rise_c | fall_c;
        toggle_q  <= toggle_q ^ rise_c;
        long_q    <= long_c;
        hold_q    <= (state_d == S_LONG);
        double_q  <= dbl_c;
      end
    end

    assign sw_if.o_press[n]   = press_q;
    assign sw_if.o_click[n]   = click_q;
    assign sw_if.o_release[n] = release_q;
    assign sw_if.o_edge[n]    = edge_q;
    assign sw_if.o_toggle[n]  = toggle_q;
    assign sw_if.o_long[n]    = long_q;
    assign sw_if.o_hold[n]    = hold_q;
    assign sw_if.o_double[n]  = double_q;
  end

endmodule

// File: tb/tb_drv_switch_array.sv
// Directed bench for drv_switch_array: debounce latency, glitch rejection,
// long press, double-click window edges and asynchronous reset.
module tb_drv_switch_array;

  localparam logic [1:0] Z  = 2'b00;
  localparam logic [1:0] C0 = 2'b01;
  localparam logic [1:0] CB = 2'b11;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic t0;

  drv_switch_array_if #(.p_channels(2)) sw ();

  drv_switch_array #(
    .p_channels    (2),
    .p_scale       (2),
    .p_pullup_mask (2'b01),
    .p_long        (20),
    .p_dbl         (10)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .sw_if (sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [1:0] tv();
    return {1'b0, t0};
  endfunction

  // Order: press, click, release, edge, toggle, long, hold, double (2 bits each)
  task automatic chk(input string tag, input logic [1:0] p, input logic [1:0] c,
                     input logic [1:0] r, input logic [1:0] t, input logic [1:0] l,
                     input logic [1:0] h, input logic [1:0] d);
    logic [15:0] obs;
    logic [15:0] exp;
    obs = {sw.o_press, sw.o_click, sw.o_release, sw.o_edge,
           sw.o_toggle, sw.o_long, sw.o_hold, sw.o_double};
    exp = {p, c, r, (c | r), t, l, h, d};
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    t0    = 1'b0;
    rst   = 1'b1;
    sw.i_drv_sw = 2'b01;
    tick(2);
    chk("reset_state", Z, Z, Z, Z, Z, Z, Z);
    rst = 1'b0;
    tick(10);
    chk("idle", Z, Z, Z, Z, Z, Z, Z);

    // ch1 (pull-down) bounces high for 3 cycles
    sw.i_drv_sw[1] = 1'b1;
    repeat (3) begin
      tick(1);
      chk("bounce_hi", Z, Z, Z, Z, Z, Z, Z);
      if (sw.o_press[1] !== 1'b0 || sw.o_edge[1] !== 1'b0) begin
        n_err++;
        $error("FAIL bounce_hi_direct: press %b edge %b", sw.o_press, sw.o_edge);
      end
    end
    sw.i_drv_sw[1] = 1'b0;
    repeat (10) begin
      tick(1);
      chk("bounce_lo", Z, Z, Z, Z, Z, Z, Z);
      if (sw.o_toggle[1] !== 1'b0 || sw.o_click[1] !== 1'b0) begin
        n_err++;
        $error("FAIL bounce_lo_direct: toggle %b click %b", sw.o_toggle, sw.o_click);
      end
    end

    // ch0 (pull-up) pressed and held into a long press
    sw.i_drv_sw[0] = 1'b0;
    tick(6);  chk("press_pre", Z, Z, Z, Z, Z, Z, Z);
    tick(1);  t0 = ~t0; chk("click", C0, C0, Z, tv(), Z, Z, Z);
    if (sw.o_click !== C0 || sw.o_press !== C0) begin
      n_err++;
      $error("FAIL click_direct: click %b press %b", sw.o_click, sw.o_press);
    end
    tick(1);  chk("click_1cyc", C0, Z, Z, tv(), Z, Z, Z);
    tick(17); chk("long_pre", C0, Z, Z, tv(), Z, Z, Z);
    tick(1);  chk("long", C0, Z, Z, tv(), C0, C0, Z);
    if (sw.o_long !== C0 || sw.o_hold !== C0) begin
      n_err++;
      $error("FAIL long_direct: long %b hold %b", sw.o_long, sw.o_hold);
    end
    tick(1);  chk("hold", C0, Z, Z, tv(), Z, C0, Z);
    tick(9);  chk("hold_late", C0, Z, Z, tv(), Z, C0, Z);
    sw.i_drv_sw[0] = 1'b1;
    tick(6);  chk("rel_pre", C0, Z, Z, tv(), Z, C0, Z);
    tick(1);  chk("rel_long", Z, Z, C0, tv(), Z, Z, Z);

    // Double click with 4-cycle gap, then a third click
    sw.i_drv_sw[0] = 1'b0; tick(7); t0 = ~t0;
    chk("dc_click1", C0, C0, Z, tv(), Z, Z, Z);
    sw.i_drv_sw[0] = 1'b1; tick(4); sw.i_drv_sw[0] = 1'b0; tick(3);
    chk("dc_rel1", Z, Z, C0, tv(), Z, Z, Z);
    tick(4); t0 = ~t0;
    chk("dc_double", C0, C0, Z, tv(), Z, Z, C0);
    if (sw.o_double !== C0 || sw.o_click !== C0) begin
      n_err++;
      $error("FAIL dc_double_direct: double %b click %b", sw.o_double, sw.o_click);
    end
    tick(1);
    chk("dc_double_1cyc", C0, Z, Z, tv(), Z, Z, Z);
    sw.i_drv_sw[0] = 1'b1; tick(4); sw.i_drv_sw[0] = 1'b0; tick(3);
    chk("dc_rel2", Z, Z, C0, tv(), Z, Z, Z);
    tick(4); t0 = ~t0;
    chk("dc_third", C0, C0, Z, tv(), Z, Z, Z);

    // Second click 12 cycles after release: window expired
    sw.i_drv_sw[0] = 1'b1; tick(7);
    chk("late_rel", Z, Z, C0, tv(), Z, Z, Z);
    tick(5); sw.i_drv_sw[0] = 1'b0; tick(7); t0 = ~t0;
    chk("late_click", C0, C0, Z, tv(), Z, Z, Z);
    sw.i_drv_sw[0] = 1'b1; tick(4); sw.i_drv_sw[0] = 1'b0; tick(3);
    chk("fresh_rel", Z, Z, C0, tv(), Z, Z, Z);
    tick(4); t0 = ~t0;
    chk("fresh_double", C0, C0, Z, tv(), Z, Z, C0);

    // Window edge: click at release+8 qualifies
    sw.i_drv_sw[0] = 1'b1; tick(7);
    chk("b8_rel0", Z, Z, C0, tv(), Z, Z, Z);
    sw.i_drv_sw[0] = 1'b0; tick(7); t0 = ~t0;
    chk("b8_click0", C0, C0, Z, tv(), Z, Z, Z);
    sw.i_drv_sw[0] = 1'b1; tick(7);
    chk("b8_rel", Z, Z, C0, tv(), Z, Z, Z);
    tick(1); sw.i_drv_sw[0] = 1'b0; tick(7); t0 = ~t0;
    chk("b8_double", C0, C0, Z, tv(), Z, Z, C0);

    // Window edge: click at release+9 does not
    sw.i_drv_sw[0] = 1'b1; tick(7);
    chk("b9_rel0", Z, Z, C0, tv(), Z, Z, Z);
    sw.i_drv_sw[0] = 1'b0; tick(7); t0 = ~t0;
    chk("b9_click0", C0, C0, Z, tv(), Z, Z, Z);
    sw.i_drv_sw[0] = 1'b1; tick(7);
    chk("b9_rel", Z, Z, C0, tv(), Z, Z, Z);
    tick(2); sw.i_drv_sw[0] = 1'b0; tick(7); t0 = ~t0;
    chk("b9_nodouble", C0, C0, Z, tv(), Z, Z, Z);
    sw.i_drv_sw[0] = 1'b1; tick(7);
    chk("b9_rel2", Z, Z, C0, tv(), Z, Z, Z);

    // Both channels held into long press, then reset mid-hold
    tick(10);
    sw.i_drv_sw = 2'b10; tick(7); t0 = ~t0;
    chk("both_click", CB, CB, Z, {1'b1, t0}, Z, Z, Z);
    tick(19);
    chk("both_long", CB, Z, Z, CB, CB, CB, Z);
    tick(2);
    chk("both_hold", CB, Z, Z, CB, Z, CB, Z);
    #2 rst = 1'b1;
    #1 chk("rst_async", Z, Z, Z, Z, Z, Z, Z);
    if (sw.o_hold !== Z || sw.o_toggle !== Z || sw.o_press !== Z) begin
      n_err++;
      $error("FAIL rst_async_direct: hold %b toggle %b press %b",
             sw.o_hold, sw.o_toggle, sw.o_press);
    end
    tick(1);
    chk("rst_held", Z, Z, Z, Z, Z, Z, Z);
    rst = 1'b0;
    tick(6);
    chk("post_rst_pre", Z, Z, Z, Z, Z, Z, Z);
    tick(1);
    chk("post_rst_click", CB, CB, Z, CB, Z, Z, Z);
    if (sw.o_click !== CB || sw.o_release !== Z) begin
      n_err++;
      $error("FAIL post_rst_direct: click %b release %b", sw.o_click, sw.o_release);
    end
    tick(1);
    chk("post_rst_steady", CB, Z, Z, CB, Z, Z, Z);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/drv_switch_array.md
# drv_switch_array

Multi-channel debounced button/toggle-switch driver with gesture detection. Each of `p_channels` raw pad inputs is synchronised, debounced and converted into a level, edge pulses, a latched toggle state, and long-press / double-click events. It sits between the board's switch pins and the application logic and replaces per-pin single-channel switch drivers.

## Interface
- `p_channels`, 4: number of independent switch channels, ≥1.
- `p_scale`, 5: debounce length is 2**`p_scale` consecutive stable cycles.
- `p_pullup_mask`, all ones: per-channel polarity.
  - Bit = 1 means pull-up wiring (pressed = pad low).
  - Bit = 0 means pull-down wiring (pressed = pad high).
- `p_long`, 50_000_000: hold duration in cycles, counted from the click, that makes a long press. ≥2.
- `p_dbl`, 15_000_000: window in cycles, after a short release, during which a second click is a double click. ≥2.

Ports:
- `i_clk`  in  1  system clock; the block uses this single clock.
- `i_rst`  in  1  reset, asynchronous and active-high.
- `i_drv_sw`  in  `p_channels`  raw switch pads, asynchronous to `i_clk`.
- `o_press`  out  `p_channels`  debounced pressed level.
- `o_click`  out  `p_channels`  1-cycle pulse on press.
- `o_release`  out  `p_channels`  1-cycle pulse on release.
- `o_edge`  out  `p_channels`  1-cycle pulse on either edge; equals `o_click | o_release`.
- `o_toggle`  out  `p_channels`  latched state that inverts on every click.
- `o_long`  out  `p_channels`  1-cycle pulse when a press reaches `p_long` cycles.
- `o_hold`  out  `p_channels`  level, high from the `o_long` cycle until release.
- `o_double`  out  `p_channels`  1-cycle pulse on the second click of a double click.

## Operation
Channels are fully independent.

**Polarity and synchronisation.** Each channel computes `raw_active = i_drv_sw[n] ^ p_pullup_mask[n]`, then passes it through a 2-flop synchroniser.

**Debounce.**
- The debounce counter is `p_scale` bits wide.
- It increments every cycle that the synchronised value differs from `o_press[n]`.
- It clears on any cycle the two are equal.
- When the counter is at 2**`p_scale`-1 and the values still differ, `o_press` takes the new value and the counter clears.
- A glitch shorter than 2**`p_scale` cycles produces no output activity.

**Edge outputs.**
- `o_click` / `o_release` are high in the first cycle that `o_press` is 1 / 0.
- `o_toggle` flips in the same cycle `o_click` is high.

**Gesture FSM.** One FSM per channel, with a saturating cycle counter of width $clog2(max(`p_long`,`p_dbl`)). The counter clears on every state change. Transitions are evaluated on the debounced click/release events:
- **IDLE:** click → PRESS.
- **PRESS:**
  - release → WAIT.
  - counter == `p_long`-1 while pressed → LONG, with `o_long` pulsed in that cycle.
- **LONG:** `o_hold`=1; release → IDLE. A release after a long press never arms the double-click window.
- **WAIT:**
  - click → DPRESS, with `o_double` pulsed in the same cycle as `o_click`.
  - counter == `p_dbl`-1 → IDLE.
- **DPRESS:**
  - release → IDLE, so a third click starts a fresh sequence (no chained doubles).
  - counter == `p_long`-1 → LONG with `o_long` pulse.

A channel's click cannot coincide with its own release, because the debounced level changes at most once per cycle.

## Timing
- **Reset values.**
  - All outputs are 0.
  - Synchronisers are forced to inactive (0 after polarity correction), so a held button at reset release produces a normal click after debounce, not a spurious release.
  - FSMs go to IDLE; counters go to 0.
- **Reset mid-operation.**
  - Immediate asynchronous clear of all state, including `o_toggle` and `o_hold`.
  - No pulse is emitted on reset assertion or deassertion.
- **Debounce latency.** If the pad changes and stays stable, the new level is first sampled at edge k. `o_press` changes at edge k + 2 + 2**`p_scale`: 2 synchroniser cycles, then 2**`p_scale` counted cycles.
- **Edge pulses.** `o_click`, `o_release`, `o_edge` and `o_double` are registered and high in exactly the same cycle that `o_press` changes.
- **Long press.** `o_long` is high exactly `p_long`-1 cycles after the `o_click` cycle, i.e. the press has then lasted `p_long` cycles including the click cycle.
- **Double-click window.** The window counts from the `o_release` cycle. A click at release+(`p_dbl`-1) exactly still sees IDLE, because the FSM leaves WAIT on that edge. The latest qualifying click is therefore at release+(`p_dbl`-2).
- **Pulse width.** Every pulse output is exactly 1 cycle wide.

## Test plan
Bench parameters: `p_channels`=2, `p_scale`=2, `p_long`=20, `p_dbl`=10, `p_pullup_mask`=2'b01.

- Channel 0 pad driven 1→0 and held → `o_press[0]` and `o_click[0]` rise 6 edges after first sample; `o_toggle[0]`=1; channel 1 silent.
- Channel 1 pad pulsed high for 3 cycles (bounce), then low → no change on any channel-1 output.
- Channel 0 held 30 cycles after click → `o_long[0]` at click+19; `o_hold[0]`=1 until `o_release[0]`; `o_double` never asserted.
- Channel 0 short click, release, second click 4 cycles after release → `o_double[0]` coincides with 2nd `o_click[0]`; `o_toggle[0]` returns to 0; third click gives no `o_double`.
- Channel 0 second click 12 cycles after release → no `o_double`; FSM back in IDLE.
- `i_rst` asserted mid-hold on both channels → all outputs 0 asynchronously; after deassert with pads still pressed → clean `o_click` 6 cycles later, no `o_release`.
